speech256_feeder: RTL and testbench

- Upstream stage of speech256_top.
- Buffers 6-bit allophone codes written by a host or controller in a small FIFO.
- Hands codes one at a time to speech256_top using that block's ldq / data_in / data_stb handshake.
- Optionally appends a pause allophone when a phrase ends, so the synthesizer returns to silence.
- A timeout guard stops the feeder from deadlocking if ldq never acknowledges.

---
 rtl/speech256_feeder_pkg.sv | 24 ++
 rtl/speech256_feeder_if.sv | 19 +
 rtl/speech256_sync_fifo.sv | 82 ++++++++
 rtl/speech256_feeder.sv | 154 +++++++++++++++
 tb/tb_speech256_feeder.sv | 394 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/speech256_feeder_pkg.sv
// -----------------------------------------------------------------------------
// speech256_feeder_pkg
// Shared definitions for the speech256 feeder slice: allophone code width,
// the standard pause allophones and the handshake FSM state encoding.
// -----------------------------------------------------------------------------
package speech256_feeder_pkg;

   localparam int CODE_W = 6;

   // Pause allophones of the SP0256 set
   localparam logic [CODE_W-1:0] PA1 = 6'd0;
   localparam logic [CODE_W-1:0] PA2 = 6'd1;
   localparam logic [CODE_W-1:0] PA3 = 6'd2;
   localparam logic [CODE_W-1:0] PA4 = 6'd3;
   localparam logic [CODE_W-1:0] PA5 = 6'd4;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      STROBE     = 2'd1,
      WAIT_ACK   = 2'd2,
      WAIT_READY = 2'd3
   } feeder_state_t;

endpackage

// File: rtl/speech256_feeder_if.sv
// -----------------------------------------------------------------------------
// speech256_feeder_if
// Load handshake between the feeder and speech256_top.
//   ldq      : synthesizer ready for a new allophone (1 = ready)
//   data_out : allophone code presented to speech256_top data_in
//   data_stb : one-cycle load strobe
// master = feeder side, slave = synthesizer side.
// -----------------------------------------------------------------------------
interface speech256_feeder_if;
   import speech256_feeder_pkg::*;

   logic              ldq;
   logic [CODE_W-1:0] data_out;
   logic              data_stb;

   modport master (input ldq, output data_out, output data_stb);
   modport slave  (output ldq, input data_out, input data_stb);

endinterface

// File: rtl/speech256_sync_fifo.sv
// -----------------------------------------------------------------------------
// speech256_sync_fifo
// Single-clock FIFO with registered occupancy flags.
//   clk, rst_an : clock, asynchronous active-low reset
//   flush       : synchronous clear (wins over push/pop)
//   push/wr_data: enqueue; ignored while full
//   pop/rd_data : dequeue; rd_data always shows the head entry
//   full, empty, level : registered, updated on the push/pop edge
// DEPTH must be a power of two (pointers wrap by natural overflow).
// -----------------------------------------------------------------------------
module speech256_sync_fifo #(
   parameter int WIDTH = 6,
   parameter int DEPTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_an,
   input  logic                   flush,
   input  logic                   push,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       rd_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             push_ok;
   logic             pop_ok;

   assign push_ok = push & ~full  & ~flush;
   assign pop_ok  = pop  & ~empty & ~flush;

   // NOTE: the storage array is deliberately not reset; entries are only
   // meaningful between rd_ptr and wr_ptr, and a reset would block RAM mapping.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leaves occupancy and flags unchanged
         case ({push_ok, pop_ok})
            2'b10: begin
               level <= level + LW'(1);
               empty <= 1'b0;
               full  <= (level == LW'(DEPTH - 1));
            end
            2'b01: begin
               level <= level - LW'(1);
               full  <= 1'b0;
               empty <= (level == LW'(1));
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/speech256_feeder.sv
// -----------------------------------------------------------------------------
// speech256_feeder
// Buffers allophone codes from a host and hands them one at a time to
// speech256_top over its ldq/data_in/data_stb handshake, optionally closing
// each phrase with a pause allophone.
//   clk, rst_an : clock, asynchronous active-low reset
//   enable      : allow new issues (an in-flight handshake always completes)
//   flush       : clear FIFO and pending auto-pause
//   wr_data, wr_stb        : host write port
//   full, empty, level     : FIFO status
//   overflow, ack_timeout  : sticky error flags, cleared only by reset
//   busy        : handshake active, codes queued, or pause pending
//   synth       : handshake to speech256_top (master modport)
// -----------------------------------------------------------------------------
module speech256_feeder
   import speech256_feeder_pkg::*;
#(
   parameter int                DEPTH       = 16,
   parameter int                ACK_TIMEOUT = 1023,
   parameter bit                AUTO_PAUSE  = 1'b1,
   parameter logic [CODE_W-1:0] PAUSE_CODE  = PA4
) (
   input  logic                   clk,
   input  logic                   rst_an,
   input  logic                   enable,
   input  logic                   flush,
   input  logic [CODE_W-1:0]      wr_data,
   input  logic                   wr_stb,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] level,
   output logic                   overflow,
   output logic                   ack_timeout,
   output logic                   busy,
   speech256_feeder_if.master     synth
);

   localparam int                CNT_W    = $clog2(ACK_TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

   feeder_state_t     state;
   feeder_state_t     next_state;
   logic [CODE_W-1:0] head;
   logic [CODE_W-1:0] data_out_q;
   logic              data_stb_q;
   logic [CNT_W-1:0]  cnt;
   logic              pause_pending;
   logic              can_issue;
   logic              cnt_expired;

   // FSM outputs
   logic              pop_head;
   logic              load_pause;
   logic              clr_cnt;
   logic              inc_cnt;
   logic              set_timeout;
   logic              stb_next;

   speech256_sync_fifo #(
      .WIDTH (CODE_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_an  (rst_an),
      .flush   (flush),
      .push    (wr_stb),
      .wr_data (wr_data),
      .pop     (pop_head),
      .rd_data (head),
      .full    (full),
      .empty   (empty),
      .level   (level)
   );

   // A flush cycle issues nothing so a discarded head is never sent
   assign can_issue   = enable & synth.ldq & ~flush;
   assign cnt_expired = (cnt == CNT_LAST);

   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) state <= IDLE;
      else         state <= next_state;
   end

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:       if (can_issue && (!empty || pause_pending)) next_state = STROBE;
         STROBE:     next_state = WAIT_ACK;
         WAIT_ACK:   if (!synth.ldq)       next_state = WAIT_READY;
                     else if (cnt_expired) next_state = IDLE;
         WAIT_READY: if (synth.ldq)        next_state = IDLE;
         default:    next_state = IDLE;
      endcase
   end

   always_comb begin
      pop_head    = 1'b0;
      load_pause  = 1'b0;
      clr_cnt     = 1'b0;
      inc_cnt     = 1'b0;
      set_timeout = 1'b0;
      stb_next    = 1'b0;
      case (state)
         IDLE: begin
            pop_head   = can_issue & ~empty;
            load_pause = can_issue & empty & pause_pending;
         end
         STROBE: begin
            clr_cnt  = 1'b1;
            stb_next = 1'b1;
         end
         WAIT_ACK: begin
            inc_cnt     = synth.ldq & ~cnt_expired;
            set_timeout = synth.ldq &  cnt_expired;
         end
         default: ;
      endcase
   end

   // data_out is loaded on the IDLE->STROBE edge and the strobe follows one
   // edge later, so the code is stable a full cycle before data_stb.
   always_ff @(posedge clk or negedge rst_an) begin
      if (!rst_an) begin
         data_out_q    <= '0;
         data_stb_q    <= 1'b0;
         cnt           <= '0;
         pause_pending <= 1'b0;
         overflow      <= 1'b0;
         ack_timeout   <= 1'b0;
      end else begin
         data_stb_q <= stb_next;

         if (pop_head)        data_out_q <= head;
         else if (load_pause) data_out_q <= PAUSE_CODE;

         if (clr_cnt)      cnt <= '0;
         else if (inc_cnt) cnt <= cnt + CNT_W'(1);

         if (set_timeout)     ack_timeout <= 1'b1;
         if (wr_stb && full)  overflow    <= 1'b1;

         // A pause issued from either source closes the phrase
         if (flush || load_pause) pause_pending <= 1'b0;
         else if (pop_head)       pause_pending <= AUTO_PAUSE && (head != PAUSE_CODE);
      end
   end

   assign busy           = (state != IDLE) | ~empty | pause_pending;
   assign synth.data_out = data_out_q;
   assign synth.data_stb = data_stb_q;

endmodule

// File: tb/tb_speech256_feeder.sv
// -----------------------------------------------------------------------------
// tb_speech256_feeder
// Self-checking bench for speech256_feeder. A synthesizer model answers each
// strobe by dropping ldq and raising it again after a programmable delay; a
// monitor logs every issued code. Expected issue sequences come from the
// phrase rule: every written code in order, then one pause if the phrase
// did not already end with the pause code.
// -----------------------------------------------------------------------------
module tb_speech256_feeder;

   localparam int         DEPTH       = 16;
   localparam int         ACK_TIMEOUT = 40;
   localparam logic [5:0] PAUSE       = 6'd3;

   typedef logic [5:0] code_q_t[$];

   logic       clk;
   logic       rst_an;
   logic       enable;
   logic       flush;
   logic [5:0] wr_data;
   logic       wr_stb;
   logic       full;
   logic       empty;
   logic [4:0] level;
   logic       overflow;
   logic       ack_timeout;
   logic       busy;

   speech256_feeder_if sif ();

   speech256_feeder #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .AUTO_PAUSE  (1'b1),
      .PAUSE_CODE  (PAUSE)
   ) dut (
      .clk         (clk),
      .rst_an      (rst_an),
      .enable      (enable),
      .flush       (flush),
      .wr_data     (wr_data),
      .wr_stb      (wr_stb),
      .full        (full),
      .empty       (empty),
      .level       (level),
      .overflow    (overflow),
      .ack_timeout (ack_timeout),
      .busy        (busy),
      .synth       (sif.master)
   );

   int pass_cnt  = 0;
   int total_cnt = 0;
   int cyc       = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Synthesizer model: in auto mode ldq idles high, falls ack_delay cycles
   // after a strobe and rises again busy_time cycles later. In manual mode
   // ldq simply follows ldq_force.
   bit resp_auto = 1'b0;
   bit ldq_force = 1'b1;
   int ack_delay = 2;
   int busy_time = 100;

   initial begin
      sif.ldq = 1'b1;
      forever begin
         @(negedge clk);
         if (resp_auto) begin
            if (sif.data_stb) begin
               repeat (ack_delay) @(negedge clk);
               sif.ldq = 1'b0;
               repeat (busy_time) @(negedge clk);
               sif.ldq = 1'b1;
            end else begin
               sif.ldq = 1'b1;
            end
         end else begin
            sif.ldq = ldq_force;
         end
      end
   end

   // Monitor: logs issued codes and their cycle, and tracks strobe protocol
   code_q_t    obs;
   int         obs_cyc[$];
   int         width_err = 0;
   int         hold_err  = 0;
   logic       prev_stb  = 1'b0;
   logic [5:0] prev_dout = '0;

   always @(negedge clk) begin
      if (sif.data_stb === 1'b1) begin
         if (prev_stb === 1'b1) width_err++;
         if (sif.data_out !== prev_dout) hold_err++;
         obs.push_back(sif.data_out);
         obs_cyc.push_back(cyc);
      end
      prev_stb  = sif.data_stb;
      prev_dout = sif.data_out;
   end

   // Reference model: a phrase is issued in write order and closed by one
   // pause unless its last code already is the pause.
   function automatic code_q_t expected_issue(input code_q_t codes);
      code_q_t e;
      e = codes;
      if (codes.size() > 0 && codes[codes.size()-1] != PAUSE) e.push_back(PAUSE);
      return e;
   endfunction

   task automatic write_burst(input code_q_t codes);
      @(negedge clk);
      foreach (codes[i]) begin
         wr_data = codes[i];
         wr_stb  = 1'b1;
         @(negedge clk);
      end
      wr_stb = 1'b0;
   endtask

   task automatic wait_idle(input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (busy === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_issues(input int n, input int bound, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (obs.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_an  = 1'b0;
      enable  = 1'b1;
      flush   = 1'b0;
      wr_data = '0;
      wr_stb  = 1'b0;
      repeat (3) @(negedge clk);
      total_cnt++; if (level !== 5'd0)    $display("FAIL reset_level: got %0d want 0", level); else pass_cnt++;
      total_cnt++; if (full !== 1'b0)     $display("FAIL reset_full: got %b want 0", full); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1)    $display("FAIL reset_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else pass_cnt++;
      total_cnt++; if (ack_timeout !== 1'b0) $display("FAIL reset_ack_timeout: got %b want 0", ack_timeout); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (sif.data_out !== 6'd0) $display("FAIL reset_data_out: got %0d want 0", sif.data_out); else pass_cnt++;
      total_cnt++; if (sif.data_stb !== 1'b0) $display("FAIL reset_data_stb: got %b want 0", sif.data_stb); else pass_cnt++;
      @(negedge clk);
      rst_an = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_single();
      code_q_t codes;
      code_q_t exp;
      int      push_cyc;
      bit      ok;
      resp_auto = 1'b1;
      ack_delay = 2;
      busy_time = 100;
      obs.delete();
      obs_cyc.delete();
      @(negedge clk);
      wr_data = 6'd7;
      wr_stb  = 1'b1;
      @(negedge clk);
      wr_stb   = 1'b0;
      push_cyc = cyc;
      codes    = '{6'd7};
      exp      = expected_issue(codes);
      wait_idle(1000, ok);
      total_cnt++; if (!ok) $display("FAIL single_idle: busy still %b after bound, want 0", busy); else pass_cnt++;
      total_cnt++;
      if (obs_cyc.size() < 1) $display("FAIL single_latency: got no strobe, want strobe at cycle %0d", push_cyc + 2);
      else if (obs_cyc[0] - push_cyc != 2) $display("FAIL single_latency: got %0d edges after push edge, want 2", obs_cyc[0] - push_cyc);
      else pass_cnt++;
      total_cnt++; if (obs.size() != exp.size()) $display("FAIL single_count: got %0d issues want %0d", obs.size(), exp.size()); else pass_cnt++;
      for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
         total_cnt++; if (obs[i] !== exp[i]) $display("FAIL single_code[%0d]: got %0d want %0d", i, obs[i], exp[i]); else pass_cnt++;
      end
   endtask

   task automatic test_burst();
      code_q_t codes;
      code_q_t exp;
      bit      ok;
      ack_delay = 1;
      busy_time = 50;
      obs.delete();
      codes = '{6'd7, 6'd20, 6'd42, 6'd3, 6'd11};
      exp   = expected_issue(codes);
      write_burst(codes);
      wait_idle(2000, ok);
      total_cnt++; if (!ok) $display("FAIL burst_idle: busy still %b after bound, want 0", busy); else pass_cnt++;
      total_cnt++; if (obs.size() != exp.size()) $display("FAIL burst_count: got %0d issues want %0d", obs.size(), exp.size()); else pass_cnt++;
      for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
         total_cnt++; if (obs[i] !== exp[i]) $display("FAIL burst_code[%0d]: got %0d want %0d", i, obs[i], exp[i]); else pass_cnt++;
      end
   endtask

   task automatic test_random_phrases();
      code_q_t codes;
      code_q_t exp;
      bit      ok;
      for (int r = 0; r < 6; r++) begin
         codes.delete();
         for (int k = 0; k < int'($urandom_range(1, 12)); k++)
            codes.push_back(($urandom_range(0, 3) == 0) ? PAUSE : 6'($urandom_range(0, 63)));
         exp       = expected_issue(codes);
         ack_delay = $urandom_range(0, 3);
         busy_time = $urandom_range(1, 20);
         obs.delete();
         write_burst(codes);
         wait_idle(2000, ok);
         total_cnt++; if (!ok) $display("FAIL rand%0d_idle: busy still %b after bound, want 0", r, busy); else pass_cnt++;
         total_cnt++; if (obs.size() != exp.size()) $display("FAIL rand%0d_count: got %0d issues want %0d", r, obs.size(), exp.size()); else pass_cnt++;
         for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
            total_cnt++; if (obs[i] !== exp[i]) $display("FAIL rand%0d_code[%0d]: got %0d want %0d", r, i, obs[i], exp[i]); else pass_cnt++;
         end
      end
   endtask

   task automatic test_timeout();
      code_q_t codes;
      code_q_t exp;
      bit      ok;
      int      t_cyc;
      resp_auto = 1'b0;
      ldq_force = 1'b1;
      obs.delete();
      obs_cyc.delete();
      codes = '{6'd9, 6'd12};
      exp   = expected_issue(codes);
      write_burst(codes);
      wait_issues(1, 50, ok);
      total_cnt++; if (!ok) $display("FAIL timeout_first_stb: got no strobe, want one"); else pass_cnt++;
      t_cyc = -1;
      for (int i = 0; i < 4 * ACK_TIMEOUT; i++) begin
         @(negedge clk);
         if (ack_timeout === 1'b1) begin
            t_cyc = cyc;
            break;
         end
      end
      total_cnt++;
      if (t_cyc < 0 || obs_cyc.size() < 1) $display("FAIL timeout_flag: ack_timeout got %b want 1", ack_timeout);
      else if (t_cyc - obs_cyc[0] != ACK_TIMEOUT) $display("FAIL timeout_delay: got %0d cycles want %0d", t_cyc - obs_cyc[0], ACK_TIMEOUT);
      else pass_cnt++;
      wait_idle(8 * ACK_TIMEOUT, ok);
      total_cnt++; if (!ok) $display("FAIL timeout_idle: busy still %b after bound, want 0", busy); else pass_cnt++;
      total_cnt++; if (obs.size() != exp.size()) $display("FAIL timeout_count: got %0d issues want %0d", obs.size(), exp.size()); else pass_cnt++;
      for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
         total_cnt++; if (obs[i] !== exp[i]) $display("FAIL timeout_code[%0d]: got %0d want %0d", i, obs[i], exp[i]); else pass_cnt++;
      end
      total_cnt++; if (ack_timeout !== 1'b1) $display("FAIL timeout_sticky: got %b want 1", ack_timeout); else pass_cnt++;
   endtask

   task automatic test_overflow();
      code_q_t codes;
      code_q_t exp;
      bit      ok;
      ldq_force = 1'b0;
      repeat (2) @(negedge clk);
      obs.delete();
      @(negedge clk);
      for (int i = 0; i < DEPTH + 1; i++) begin
         wr_data = 6'(10 + i);
         wr_stb  = 1'b1;
         if (i < DEPTH) codes.push_back(6'(10 + i));
         @(negedge clk);
         if (i == DEPTH - 1) begin
            total_cnt++; if (full !== 1'b1)     $display("FAIL ovf_full16: got %b want 1", full); else pass_cnt++;
            total_cnt++; if (overflow !== 1'b0) $display("FAIL ovf_early: got %b want 0", overflow); else pass_cnt++;
         end
      end
      wr_stb = 1'b0;
      total_cnt++; if (overflow !== 1'b1)   $display("FAIL ovf_flag: got %b want 1", overflow); else pass_cnt++;
      total_cnt++; if (level !== 5'(DEPTH)) $display("FAIL ovf_level: got %0d want %0d", level, DEPTH); else pass_cnt++;
      total_cnt++; if (obs.size() != 0)     $display("FAIL ovf_no_issue: got %0d issues want 0", obs.size()); else pass_cnt++;
      exp       = expected_issue(codes);
      ack_delay = 1;
      busy_time = 5;
      resp_auto = 1'b1;
      wait_idle(3000, ok);
      total_cnt++; if (!ok) $display("FAIL ovf_idle: busy still %b after bound, want 0", busy); else pass_cnt++;
      total_cnt++; if (obs.size() != exp.size()) $display("FAIL ovf_count: got %0d issues want %0d", obs.size(), exp.size()); else pass_cnt++;
      for (int i = 0; i < exp.size() && i < obs.size(); i++) begin
         total_cnt++; if (obs[i] !== exp[i]) $display("FAIL ovf_code[%0d]: got %0d want %0d", i, obs[i], exp[i]); else pass_cnt++;
      end
   endtask

   task automatic test_enable_flush();
      code_q_t codes;
      bit      ok;
      ack_delay = 1;
      busy_time = 10;
      obs.delete();
      codes = '{6'd25};
      write_burst(codes);
      wait_issues(1, 50, ok);
      total_cnt++; if (!ok) $display("FAIL ef_first_stb: got no strobe, want one"); else pass_cnt++;
      enable = 1'b0;
      repeat (30) @(negedge clk);
      // Handshake done, pause still owed but held back by enable
      total_cnt++; if (busy !== 1'b1) $display("FAIL ef_pending_busy: got %b want 1", busy); else pass_cnt++;
      codes = '{6'd30, 6'd31, 6'd32, 6'd33};
      write_burst(codes);
      repeat (20) @(negedge clk);
      total_cnt++; if (obs.size() != 1) $display("FAIL ef_disabled: got %0d issues want 1", obs.size()); else pass_cnt++;
      total_cnt++; if (level !== 5'd4)  $display("FAIL ef_level: got %0d want 4", level); else pass_cnt++;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      total_cnt++; if (level !== 5'd0)    $display("FAIL ef_flush_level: got %0d want 0", level); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1)    $display("FAIL ef_flush_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0)     $display("FAIL ef_flush_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b1) $display("FAIL ef_flush_sticky: got %b want 1", overflow); else pass_cnt++;
      enable = 1'b1;
      repeat (30) @(negedge clk);
      total_cnt++; if (obs.size() != 1) $display("FAIL ef_after_enable: got %0d issues want 1", obs.size()); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      code_q_t codes;
      bit      ok;
      int      n;
      resp_auto = 1'b0;
      ldq_force = 1'b1;
      repeat (2) @(negedge clk);
      obs.delete();
      codes = '{6'd50, 6'd51};
      write_burst(codes);
      wait_issues(1, 50, ok);
      total_cnt++; if (!ok) $display("FAIL rm_stb: got no strobe, want one"); else pass_cnt++;
      repeat (3) @(negedge clk);
      rst_an = 1'b0;
      #1;
      total_cnt++; if (sif.data_stb !== 1'b0) $display("FAIL rm_data_stb: got %b want 0", sif.data_stb); else pass_cnt++;
      total_cnt++; if (sif.data_out !== 6'd0) $display("FAIL rm_data_out: got %0d want 0", sif.data_out); else pass_cnt++;
      total_cnt++; if (empty !== 1'b1)        $display("FAIL rm_empty: got %b want 1", empty); else pass_cnt++;
      total_cnt++; if (level !== 5'd0)        $display("FAIL rm_level: got %0d want 0", level); else pass_cnt++;
      total_cnt++; if (busy !== 1'b0)         $display("FAIL rm_busy: got %b want 0", busy); else pass_cnt++;
      total_cnt++; if (ack_timeout !== 1'b0)  $display("FAIL rm_ack_timeout: got %b want 0", ack_timeout); else pass_cnt++;
      total_cnt++; if (overflow !== 1'b0)     $display("FAIL rm_overflow: got %b want 0", overflow); else pass_cnt++;
      @(negedge clk);
      rst_an    = 1'b1;
      resp_auto = 1'b1;
      n = obs.size();
      repeat (20) @(negedge clk);
      total_cnt++; if (obs.size() != n) $display("FAIL rm_no_issue: got %0d new issues want 0", obs.size() - n); else pass_cnt++;
   endtask

   task automatic test_stb_protocol();
      total_cnt++; if (width_err != 0) $display("FAIL stb_width: got %0d multi-cycle strobes want 0", width_err); else pass_cnt++;
      total_cnt++; if (hold_err != 0)  $display("FAIL stb_setup: got %0d strobes with unsettled data want 0", hold_err); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_random_phrases();
      test_timeout();
      test_overflow();
      test_enable_flush();
      test_reset_mid();
      test_stb_protocol();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", pass_cnt, total_cnt);
      $fatal(1, "watchdog");
   end

endmodule
